// File: rtl/bcd_pkg.sv
// Shared constants for the 4-digit BCD counter and its multiplexed 7-segment scan.
package bcd_pkg;

   localparam int unsigned NDIG    = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   // Active-low digit enables, indexed by scan position (0 = units)
   localparam logic [3:0] SEL_PAT [NDIG] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   typedef enum logic [1:0] {
      DIG_UNITS     = 2'd0,
      DIG_TENS      = 2'd1,
      DIG_HUNDREDS  = 2'd2,
      DIG_THOUSANDS = 2'd3
   } digit_idx_t;

   function automatic logic [3:0] bcd_sanitize(input logic [3:0] n);
      return (n > BCD_MAX) ? '0 : n;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: loadable, bidirectional, with a combinational
// terminal-count flag used to build the enable chain.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] d,
   input  logic       en,
   input  logic       up,
   output logic [3:0] q,
   output logic       co
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= bcd_sanitize(d);
      end else if (en) begin
         if (up) begin
            q <= (q == BCD_MAX) ? '0 : q + 4'd1;
         end else begin
            q <= (q == '0) ? BCD_MAX : q - 4'd1;
         end
      end
   end

   assign co = up ? (q == BCD_MAX) : (q == '0);

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with wrap pulse and a time-multiplexed digit
// scan for a common-anode style 7-segment display.
module bcd_scan_counter
   import bcd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] count,
   output logic        carry,
   output logic [3:0]  digit,
   output logic [3:0]  sel
);

   localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [NDIG-1:0] co;
   logic [NDIG:0]   dig_en;
   logic [DIV_W-1:0] div;
   digit_idx_t      idx;
   digit_idx_t      nxt_idx;

   // Each digit steps only when every lower digit is at its terminal value;
   // the top entry of the chain is therefore the wrap condition.
   assign dig_en[0] = en;
   for (genvar g = 1; g <= NDIG; g++) begin : g_chain
      assign dig_en[g] = en & (&co[g-1:0]);
   end

   for (genvar g = 0; g < NDIG; g++) begin : g_digit
      bcd_digit u_digit (
         .clk  (clk),
         .rst  (rst),
         .load (load),
         .d    (load_val[4*g +: 4]),
         .en   (dig_en[g]),
         .up   (up),
         .q    (count[4*g +: 4]),
         .co   (co[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry <= 1'b0;
      end else begin
         carry <= ~load & dig_en[NDIG];
      end
   end

   assign nxt_idx = digit_idx_t'(idx + 2'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
         idx <= DIG_UNITS;
         sel <= SEL_PAT[0];
      end else if (div == DIV_LAST) begin
         div <= '0;
         idx <= nxt_idx;
         sel <= SEL_PAT[nxt_idx];
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   always_comb begin
      digit = '0;
      unique case (idx)
         DIG_UNITS:     digit = count[3:0];
         DIG_TENS:      digit = count[7:4];
         DIG_HUNDREDS:  digit = count[11:8];
         DIG_THOUSANDS: digit = count[15:12];
         default:       digit = '0;
      endcase
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: a decimal-integer reference model predicts each cycle's
// outputs and a monitor compares them against the counter.
module tb_bcd_scan_counter;

   localparam int unsigned DIV = 4;

   logic        clk = 1'b0;
   logic        rst, en, up, load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        carry;
   logic [3:0]  digit, sel;

   bcd_scan_counter #(.SCAN_DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .carry    (carry),
      .digit    (digit),
      .sel      (sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] count;
      logic        carry;
      logic [3:0]  sel;
      logic [3:0]  digit;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   pushed = 0;
   int   popped = 0;

   // Reference state: counter value as a plain decimal integer 0..9999
   int m_val, m_div, m_idx;
   bit m_carry;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int decode_load(input logic [15:0] lv);
      int v, p;
      logic [3:0] n;
      v = 0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
         n = lv[4*i +: 4];
         if (n <= 4'd9) v += int'(n) * p;
         p *= 10;
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step(input bit r, input bit ld, input logic [15:0] lv, input bit e, input bit u);
      exp_t ex;
      int   p;
      rst = r; load = ld; load_val = lv; en = e; up = u;
      if (r) begin
         m_val = 0; m_carry = 0; m_div = 0; m_idx = 0;
      end else begin
         if (ld) begin
            m_val = decode_load(lv);
            m_carry = 0;
         end else if (e) begin
            if (u) begin
               m_carry = (m_val == 9999);
               m_val = (m_val + 1) % 10000;
            end else begin
               m_carry = (m_val == 0);
               m_val = (m_val + 9999) % 10000;
            end
         end else begin
            m_carry = 0;
         end
         if (m_div == int'(DIV) - 1) begin
            m_div = 0;
            m_idx = (m_idx + 1) % 4;
         end else begin
            m_div++;
         end
      end
      p = 1;
      for (int i = 0; i < m_idx; i++) p *= 10;
      ex.count = to_bcd(m_val);
      ex.carry = m_carry;
      ex.sel   = ~(4'b0001 << m_idx);
      ex.digit = 4'((m_val / p) % 10);
      sb.push_back(ex);
      pushed++;
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t ex;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            ex = sb.pop_front();
            popped++;
            chk("count", count, ex.count);
            chk("carry", {15'b0, carry}, {15'b0, ex.carry});
            chk("sel",   {12'b0, sel},   {12'b0, ex.sel});
            chk("digit", {12'b0, digit}, {12'b0, ex.digit});
         end
      end
   end

   initial begin : stimulus
      bit          r, ld, e, u;
      logic [15:0] lv;
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

      // Reset then twelve up steps
      step(1, 0, 16'h0000, 0, 1);
      repeat (12) step(0, 0, 16'h0000, 1, 1);

      // Up wrap through 9999
      step(0, 1, 16'h9998, 0, 1);
      step(0, 0, 16'h0000, 1, 1);
      step(0, 0, 16'h0000, 1, 1);
      step(0, 0, 16'h0000, 0, 1);

      // Down borrow and down wrap
      step(0, 1, 16'h1000, 0, 0);
      step(0, 0, 16'h0000, 1, 0);
      step(0, 1, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 1, 0);
      step(0, 0, 16'h0000, 0, 0);

      // Load wins over enable, illegal nibbles cleared
      step(0, 1, 16'hA5F3, 1, 1);
      step(0, 0, 16'h0000, 0, 1);

      // Scan sequence over a held value
      step(1, 0, 16'h0000, 0, 1);
      step(0, 1, 16'h1234, 0, 1);
      repeat (32) step(0, 0, 16'h0000, 0, 1);

      // Reset mid-run beats load and enable
      repeat (6) step(0, 0, 16'h0000, 1, 1);
      step(1, 1, 16'h5555, 1, 1);
      step(0, 0, 16'h0000, 1, 1);

      repeat (600) begin
         r  = ($urandom_range(0, 49) == 0);
         ld = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       lv = 16'($urandom());
            1:       lv = 16'h9998;
            2:       lv = 16'h0001;
            default: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         endcase
         e = ($urandom_range(0, 3) != 0);
         u = ($urandom_range(0, 1) == 1);
         step(r, ld, lv, e, u);
      end

      repeat (3) @(posedge clk);
      chk("drain", 16'(sb.size()), 16'd0);
      chk("popped", 16'(popped), 16'(pushed));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
